// File: rtl/csr_pkg.sv
// csr_pkg: shared constants for the machine-mode CSR file.
// Holds the CSR address map, the mstatus bit positions, the misa and
// mstatus reset constants, and a helper that assembles the mstatus read
// value from the two stored interrupt-enable bits.
package csr_pkg;

  // Machine information registers
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  // Machine trap setup and handling
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;

  // Machine counters and their user-level read-only aliases
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  // mstatus fields that are actually implemented
  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  // MPP is hardwired to machine mode (2'b11 in bits 12:11)
  localparam logic [31:0] MSTATUS_RESET = 32'h0000_1800;
  // RV32 base ISA with the I extension only
  localparam logic [31:0] MISA_VALUE    = 32'h4000_0100;

  // Build the architectural mstatus view from the stored MIE/MPIE bits.
  function automatic logic [31:0] mstatus_view(input logic mie, input logic mpie);
    logic [31:0] value;
    value = MSTATUS_RESET;
    value[MSTATUS_MIE_BIT]  = mie;
    value[MSTATUS_MPIE_BIT] = mpie;
    return value;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit event counter whose halves are individually
// writable through the CSR port.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   inc_en            count one event this cycle
//   wr_lo / wr_hi     load the low / high word from wr_data
//   wr_data           CSR write data
//   count             current 64-bit count
module csr_counter64 (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc_en,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wr_data,
  output logic [63:0] count
);

  // A write to either half replaces that half and freezes the other one for
  // the cycle, so software sees exactly the value it wrote with no increment
  // or carry mixed in.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (wr_lo) begin
      count[31:0] <= wr_data;
    end else if (wr_hi) begin
      count[63:32] <= wr_data;
    end else if (inc_en) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file for a single-hart RV32 core.
// Ports:
//   clk, reset                    clock and synchronous active-high reset
//   stop                          pipeline stall; blocks writes, traps, mret, retire
//   csr_addr / csr_data           combinational read port
//   csr_illegal                   csr_addr is not an implemented CSR
//   wb_csr, wb_csr_addr/_data     write-back port
//   trap_valid, trap_cause/_pc/_tval  trap entry request and its payload
//   mret                          trap return
//   retire                        one instruction retired this cycle
//   csr_trap_vec_data             trap target address (direct mode)
//   csr_exception_pc_data         current mepc
//   irq_enable                    mstatus.MIE
module csr_file
  import csr_pkg::*;
#(
  parameter logic [31:0] HART_ID     = 32'h0,
  parameter logic [31:0] MTVEC_RESET = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stop,
  input  logic [11:0] csr_addr,
  output logic [31:0] csr_data,
  output logic        csr_illegal,
  input  logic        wb_csr,
  input  logic [11:0] wb_csr_addr,
  input  logic [31:0] wb_csr_data,
  input  logic        trap_valid,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_tval,
  input  logic        mret,
  input  logic        retire,
  output logic [31:0] csr_trap_vec_data,
  output logic [31:0] csr_exception_pc_data,
  output logic        irq_enable
);

  logic        wb_we;
  logic        trap_en;
  logic        mret_en;

  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic [31:0] mtvec;
  logic [31:0] mie_reg;
  logic [31:0] mscratch;
  logic [31:0] mepc;
  logic [31:0] mcause;
  logic [31:0] mtval;
  logic [63:0] mcycle;
  logic [63:0] minstret;

  assign wb_we   = wb_csr && !stop;
  assign trap_en = trap_valid && !stop;
  assign mret_en = mret && !stop;

  // Registers touched by trap entry / return. A trap owns them outright for
  // the cycle; mret then takes mstatus ahead of a software write.
  always_ff @(posedge clk) begin
    if (reset) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mepc         <= '0;
      mcause       <= '0;
      mtval        <= '0;
    end else if (trap_en) begin
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
      mepc         <= {trap_pc[31:2], 2'b00};
      mcause       <= trap_cause;
      mtval        <= trap_tval;
    end else begin
      if (mret_en) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else if (wb_we && wb_csr_addr == CSR_MSTATUS) begin
        mstatus_mie  <= wb_csr_data[MSTATUS_MIE_BIT];
        mstatus_mpie <= wb_csr_data[MSTATUS_MPIE_BIT];
      end
      if (wb_we && wb_csr_addr == CSR_MEPC)   mepc   <= {wb_csr_data[31:2], 2'b00};
      if (wb_we && wb_csr_addr == CSR_MCAUSE) mcause <= wb_csr_data;
      if (wb_we && wb_csr_addr == CSR_MTVAL)  mtval  <= wb_csr_data;
    end
  end

  // Plain software-only registers; traps never touch these.
  always_ff @(posedge clk) begin
    if (reset) begin
      mtvec    <= {MTVEC_RESET[31:2], 2'b00};
      mie_reg  <= '0;
      mscratch <= '0;
    end else if (wb_we) begin
      if (wb_csr_addr == CSR_MTVEC)    mtvec    <= {wb_csr_data[31:2], 2'b00};
      if (wb_csr_addr == CSR_MIE)      mie_reg  <= wb_csr_data;
      if (wb_csr_addr == CSR_MSCRATCH) mscratch <= wb_csr_data;
    end
  end

  // The cycle counter keeps running through stalls; instret only counts
  // retirements that are not stalled.
  csr_counter64 u_cycle (
    .clk     (clk),
    .reset   (reset),
    .inc_en  (1'b1),
    .wr_lo   (wb_we && wb_csr_addr == CSR_MCYCLE),
    .wr_hi   (wb_we && wb_csr_addr == CSR_MCYCLEH),
    .wr_data (wb_csr_data),
    .count   (mcycle)
  );

  csr_counter64 u_instret (
    .clk     (clk),
    .reset   (reset),
    .inc_en  (retire && !stop),
    .wr_lo   (wb_we && wb_csr_addr == CSR_MINSTRET),
    .wr_hi   (wb_we && wb_csr_addr == CSR_MINSTRETH),
    .wr_data (wb_csr_data),
    .count   (minstret)
  );

  // Read mux straight off the registers; a write in flight is not forwarded.
  always_comb begin
    csr_data    = '0;
    csr_illegal = 1'b0;
    case (csr_addr)
      CSR_MSTATUS:                 csr_data = mstatus_view(mstatus_mie, mstatus_mpie);
      CSR_MISA:                    csr_data = MISA_VALUE;
      CSR_MIE:                     csr_data = mie_reg;
      CSR_MTVEC:                   csr_data = mtvec;
      CSR_MSCRATCH:                csr_data = mscratch;
      CSR_MEPC:                    csr_data = mepc;
      CSR_MCAUSE:                  csr_data = mcause;
      CSR_MTVAL:                   csr_data = mtval;
      CSR_MCYCLE,   CSR_CYCLE:     csr_data = mcycle[31:0];
      CSR_MCYCLEH,  CSR_CYCLEH:    csr_data = mcycle[63:32];
      CSR_MINSTRET, CSR_INSTRET:   csr_data = minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: csr_data = minstret[63:32];
      CSR_MVENDORID, CSR_MARCHID,
      CSR_MIMPID:                  csr_data = '0;
      CSR_MHARTID:                 csr_data = HART_ID;
      default:                     csr_illegal = 1'b1;
    endcase
  end

  assign csr_trap_vec_data     = {mtvec[31:2], 2'b00};
  assign csr_exception_pc_data = mepc;
  assign irq_enable            = mstatus_mie;

endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed self-checking bench for csr_file.
module tb_csr_file;

  localparam logic [31:0] HART_ID     = 32'h0000_0007;
  localparam logic [31:0] MTVEC_RESET = 32'h0000_2003;

  logic        clk = 1'b0;
  logic        reset;
  logic        stop;
  logic [11:0] csr_addr;
  logic [31:0] csr_data;
  logic        csr_illegal;
  logic        wb_csr;
  logic [11:0] wb_csr_addr;
  logic [31:0] wb_csr_data;
  logic        trap_valid;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic [31:0] trap_tval;
  logic        mret;
  logic        retire;
  logic [31:0] csr_trap_vec_data;
  logic [31:0] csr_exception_pc_data;
  logic        irq_enable;

  int vectors = 0;
  int errors  = 0;

  csr_file #(.HART_ID(HART_ID), .MTVEC_RESET(MTVEC_RESET)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .stop                  (stop),
    .csr_addr              (csr_addr),
    .csr_data              (csr_data),
    .csr_illegal           (csr_illegal),
    .wb_csr                (wb_csr),
    .wb_csr_addr           (wb_csr_addr),
    .wb_csr_data           (wb_csr_data),
    .trap_valid            (trap_valid),
    .trap_cause            (trap_cause),
    .trap_pc               (trap_pc),
    .trap_tval             (trap_tval),
    .mret                  (mret),
    .retire                (retire),
    .csr_trap_vec_data     (csr_trap_vec_data),
    .csr_exception_pc_data (csr_exception_pc_data),
    .irq_enable            (irq_enable)
  );

  always #5 clk = ~clk;

  // Advance one clock edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a read address and let the combinational mux settle.
  task automatic rd(input logic [11:0] a);
    csr_addr = a;
    #1;
  endtask

  // Single write cycle through the write-back port.
  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    wb_csr = 1'b1; wb_csr_addr = a; wb_csr_data = d;
    tick();
    wb_csr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wb_csr = 1'b1; wb_csr_addr = 12'h340; wb_csr_data = 32'h0000_00AA;
    trap_valid = 1'b1; trap_pc = 32'h0000_1234; mret = 1'b1; retire = 1'b1;
    tick(); tick();
    reset = 1'b0; wb_csr = 1'b0; trap_valid = 1'b0; mret = 1'b0; retire = 1'b0;
    vectors++; if (csr_trap_vec_data !== 32'h0000_2000) begin errors++; $display("[TB] FAIL reset_trap_vec: got %h want %h", csr_trap_vec_data, 32'h0000_2000); end
    vectors++; if (csr_exception_pc_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_mepc: got %h want 0", csr_exception_pc_data); end
    vectors++; if (irq_enable !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq_enable: got %b want 0", irq_enable); end
    rd(12'h300);
    vectors++; if (csr_data !== 32'h0000_1800) begin errors++; $display("[TB] FAIL reset_mstatus: got %h want 00001800", csr_data); end
    vectors++; if (csr_illegal !== 1'b0) begin errors++; $display("[TB] FAIL mstatus_legal: got %b want 0", csr_illegal); end
    rd(12'h301);
    vectors++; if (csr_data !== 32'h4000_0100) begin errors++; $display("[TB] FAIL misa: got %h want 40000100", csr_data); end
    rd(12'hF14);
    vectors++; if (csr_data !== 32'h0000_0007) begin errors++; $display("[TB] FAIL mhartid: got %h want 00000007", csr_data); end
    rd(12'h7C0);
    vectors++; if (csr_illegal !== 1'b1) begin errors++; $display("[TB] FAIL illegal_flag: got %b want 1", csr_illegal); end
    vectors++; if (csr_data !== 32'h0) begin errors++; $display("[TB] FAIL illegal_data: got %h want 0", csr_data); end
    rd(12'h340);
    vectors++; if (csr_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_beats_write: got %h want 0", csr_data); end
  endtask

  task automatic test_mtvec_misa();
    wr(12'h305, 32'h8000_0103);
    vectors++; if (csr_trap_vec_data !== 32'h8000_0100) begin errors++; $display("[TB] FAIL trap_vec: got %h want 80000100", csr_trap_vec_data); end
    rd(12'h305);
    vectors++; if (csr_data !== 32'h8000_0100) begin errors++; $display("[TB] FAIL mtvec_read: got %h want 80000100", csr_data); end
    wr(12'h301, 32'h0);
    rd(12'h301);
    vectors++; if (csr_data !== 32'h4000_0100) begin errors++; $display("[TB] FAIL misa_readonly: got %h want 40000100", csr_data); end
    // Pending write is not visible on the read port before the edge.
    rd(12'h340);
    wb_csr = 1'b1; wb_csr_addr = 12'h340; wb_csr_data = 32'hDEAD_BEEF;
    #1;
    vectors++; if (csr_data !== 32'h0) begin errors++; $display("[TB] FAIL no_forwarding: got %h want 0", csr_data); end
    tick();
    wb_csr = 1'b0;
    vectors++; if (csr_data !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL mscratch: got %h want deadbeef", csr_data); end
  endtask

  task automatic test_trap_mret();
    wr(12'h300, 32'h0000_0008);
    vectors++; if (irq_enable !== 1'b1) begin errors++; $display("[TB] FAIL mie_set: got %b want 1", irq_enable); end
    rd(12'h300);
    vectors++; if (csr_data !== 32'h0000_1808) begin errors++; $display("[TB] FAIL mstatus_mie: got %h want 00001808", csr_data); end
    trap_valid = 1'b1; trap_pc = 32'h0000_1006; trap_cause = 32'd2; trap_tval = 32'd5;
    tick();
    trap_valid = 1'b0;
    vectors++; if (csr_exception_pc_data !== 32'h0000_1004) begin errors++; $display("[TB] FAIL trap_mepc: got %h want 00001004", csr_exception_pc_data); end
    vectors++; if (irq_enable !== 1'b0) begin errors++; $display("[TB] FAIL trap_mie: got %b want 0", irq_enable); end
    rd(12'h342);
    vectors++; if (csr_data !== 32'd2) begin errors++; $display("[TB] FAIL trap_mcause: got %h want 2", csr_data); end
    rd(12'h343);
    vectors++; if (csr_data !== 32'd5) begin errors++; $display("[TB] FAIL trap_mtval: got %h want 5", csr_data); end
    rd(12'h300);
    vectors++; if (csr_data !== 32'h0000_1880) begin errors++; $display("[TB] FAIL trap_mstatus: got %h want 00001880", csr_data); end
    mret = 1'b1;
    tick();
    mret = 1'b0;
    vectors++; if (csr_data !== 32'h0000_1888) begin errors++; $display("[TB] FAIL mret_mstatus: got %h want 00001888", csr_data); end
    vectors++; if (irq_enable !== 1'b1) begin errors++; $display("[TB] FAIL mret_mie: got %b want 1", irq_enable); end
  endtask

  task automatic test_mcycle();
    wr(12'hB00, 32'hFFFF_FFFF);
    rd(12'hB00);
    vectors++; if (csr_data !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL mcycle_write: got %h want ffffffff", csr_data); end
    tick();
    vectors++; if (csr_data !== 32'h0) begin errors++; $display("[TB] FAIL mcycle_wrap: got %h want 0", csr_data); end
    rd(12'hB80);
    vectors++; if (csr_data !== 32'd1) begin errors++; $display("[TB] FAIL mcycleh_carry: got %h want 1", csr_data); end
    rd(12'hC80);
    vectors++; if (csr_data !== 32'd1) begin errors++; $display("[TB] FAIL cycleh_alias: got %h want 1", csr_data); end
    // Write the high word in the very cycle the low word would carry.
    wr(12'hB00, 32'hFFFF_FFFF);
    wr(12'hB80, 32'h0000_0055);
    rd(12'hB80);
    vectors++; if (csr_data !== 32'h55) begin errors++; $display("[TB] FAIL mcycleh_write_wins: got %h want 55", csr_data); end
    rd(12'hB00);
    vectors++; if (csr_data !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL mcycle_hold: got %h want ffffffff", csr_data); end
    tick();
    vectors++; if (csr_data !== 32'h0) begin errors++; $display("[TB] FAIL mcycle_after_hold: got %h want 0", csr_data); end
    rd(12'hB80);
    vectors++; if (csr_data !== 32'h56) begin errors++; $display("[TB] FAIL mcycleh_after_hold: got %h want 56", csr_data); end
    // Read-only alias ignores writes; counter keeps running through stop.
    wr(12'hB00, 32'h0000_0100);
    wr(12'hC00, 32'h0);
    rd(12'hB00);
    vectors++; if (csr_data !== 32'h101) begin errors++; $display("[TB] FAIL cycle_alias_ro: got %h want 101", csr_data); end
    stop = 1'b1;
    tick(); tick();
    stop = 1'b0;
    vectors++; if (csr_data !== 32'h103) begin errors++; $display("[TB] FAIL mcycle_during_stop: got %h want 103", csr_data); end
  endtask

  task automatic test_instret_stop();
    wr(12'hB02, 32'h0);
    wr(12'hB82, 32'h0);
    retire = 1'b1;
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    retire = 1'b0;
    rd(12'hB02);
    vectors++; if (csr_data !== 32'd2) begin errors++; $display("[TB] FAIL minstret: got %h want 2", csr_data); end
    rd(12'hC02);
    vectors++; if (csr_data !== 32'd2) begin errors++; $display("[TB] FAIL instret_alias: got %h want 2", csr_data); end
    rd(12'hB82);
    vectors++; if (csr_data !== 32'd0) begin errors++; $display("[TB] FAIL minstreth: got %h want 0", csr_data); end
    stop = 1'b1;
    wr(12'h340, 32'h0000_0077);
    stop = 1'b0;
    rd(12'h340);
    vectors++; if (csr_data !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL write_during_stop: got %h want deadbeef", csr_data); end
  endtask

  task automatic test_priority();
    wb_csr = 1'b1; wb_csr_addr = 12'h341; wb_csr_data = 32'h0000_0040;
    trap_valid = 1'b1; trap_pc = 32'h0000_2008; trap_cause = 32'h0000_000B; trap_tval = 32'h0;
    tick();
    wb_csr = 1'b0; trap_valid = 1'b0;
    vectors++; if (csr_exception_pc_data !== 32'h0000_2008) begin errors++; $display("[TB] FAIL trap_beats_mepc_write: got %h want 00002008", csr_exception_pc_data); end
    rd(12'h342);
    vectors++; if (csr_data !== 32'h0000_000B) begin errors++; $display("[TB] FAIL trap_mcause2: got %h want 0000000b", csr_data); end
    wb_csr = 1'b1; wb_csr_addr = 12'h340; wb_csr_data = 32'h0000_0099;
    trap_valid = 1'b1; trap_pc = 32'h0000_300C;
    tick();
    wb_csr = 1'b0; trap_valid = 1'b0;
    rd(12'h340);
    vectors++; if (csr_data !== 32'h0000_0099) begin errors++; $display("[TB] FAIL other_write_with_trap: got %h want 00000099", csr_data); end
    vectors++; if (csr_exception_pc_data !== 32'h0000_300C) begin errors++; $display("[TB] FAIL trap_mepc3: got %h want 0000300c", csr_exception_pc_data); end
    wr(12'h300, 32'h0000_0088);
    trap_valid = 1'b1; mret = 1'b1;
    tick();
    trap_valid = 1'b0; mret = 1'b0;
    vectors++; if (irq_enable !== 1'b0) begin errors++; $display("[TB] FAIL trap_beats_mret: got %b want 0", irq_enable); end
    rd(12'h300);
    vectors++; if (csr_data !== 32'h0000_1880) begin errors++; $display("[TB] FAIL trap_mret_mstatus: got %h want 00001880", csr_data); end
  endtask

  initial begin
    reset = 1'b1; stop = 1'b0; csr_addr = 12'h0;
    wb_csr = 1'b0; wb_csr_addr = 12'h0; wb_csr_data = 32'h0;
    trap_valid = 1'b0; trap_cause = 32'h0; trap_pc = 32'h0; trap_tval = 32'h0;
    mret = 1'b0; retire = 1'b0;
    #2;
    test_reset();
    test_mtvec_misa();
    test_trap_mret();
    test_mcycle();
    test_instret_stop();
    test_priority();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
